// File: rtl/injection_scheduler.sv
// Packet injector from a PE network interface into a router local port: round-robin VC pick, HEAD/BODY/TAIL segmentation,
// flit-by-flit on_off backpressure. `INJ_STATS_EN adds saturating packet/flit/stall counters.
module injection_scheduler #(
    parameter int VC_NUM           = 2,
    parameter int MAX_PKT_LEN      = 8,
    parameter int DEST_ADDR_SIZE_X = 4,
    parameter int DEST_ADDR_SIZE_Y = 4,
    parameter int BT_PAYLOAD_SIZE  = 16,
    localparam int VC_W            = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int LEN_W           = $clog2(MAX_PKT_LEN + 1),
    localparam int FLIT_W          = 2 + VC_W + BT_PAYLOAD_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid_i,
    output logic                        pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] pkt_dest_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_dest_y_i,
    input  logic [LEN_W-1:0]            pkt_len_i,
    input  logic                        pl_valid_i,
    input  logic [BT_PAYLOAD_SIZE-1:0]  pl_i,
    output logic                        pl_ready_o,
    output logic [FLIT_W-1:0]           data_o,
    output logic                        valid_flit_o,
    input  logic [VC_NUM-1:0]           on_off_i,
    input  logic [VC_NUM-1:0]           is_allocatable_i,
    output logic                        busy_o
`ifdef INJ_STATS_EN
    ,
    output logic [31:0]                 stat_pkts_o,
    output logic [31:0]                 stat_flits_o,
    output logic [31:0]                 stat_stall_o
`endif
);

    localparam int HEAD_PL_W = BT_PAYLOAD_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        LBL_HEAD     = 2'b00,
        LBL_BODY     = 2'b01,
        LBL_TAIL     = 2'b10,
        LBL_HEADTAIL = 2'b11
    } flit_label_e;

    // HEAD/HEADTAIL payload field is {dest_x, dest_y, low HEAD_PL_W bits of pl_i}.
    typedef struct packed {
        flit_label_e                label;
        logic [VC_W-1:0]            vc_id;
        logic [BT_PAYLOAD_SIZE-1:0] data;
    } flit_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [VC_W-1:0]             r_vc;
    logic [VC_W-1:0]             r_last_vc;
    logic [DEST_ADDR_SIZE_X-1:0] r_dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0] r_dest_y;
    logic [LEN_W-1:0]            r_len;
    logic [LEN_W-1:0]            r_cnt;
    flit_t                       r_flit;
    logic                        r_flit_vld;

    logic                        w_pkt_hs;
    logic                        w_pl_hs;
    logic                        w_last;
    logic [VC_W-1:0]             w_sel_vc;
    logic                        w_sel_found;
    logic [LEN_W-1:0]            w_len_clamped;
    flit_t                       w_flit;

    assign w_len_clamped = (pkt_len_i == '0)                  ? LEN_W'(1) :
                           (pkt_len_i > LEN_W'(MAX_PKT_LEN)) ? LEN_W'(MAX_PKT_LEN) :
                                                                pkt_len_i;

    assign w_last = (r_cnt == r_len - LEN_W'(1));

    // Round-robin: first allocatable VC strictly after the last one used, wrapping.
    always_comb begin
        w_sel_vc    = '0;
        w_sel_found = 1'b0;
        for (int k = 1; k <= VC_NUM; k++) begin
            if (!w_sel_found && is_allocatable_i[(int'(r_last_vc) + k) % VC_NUM]) begin
                w_sel_vc    = VC_W'((int'(r_last_vc) + k) % VC_NUM);
                w_sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        pkt_ready_o = 1'b0;
        pl_ready_o  = 1'b0;
        w_pkt_hs    = 1'b0;
        w_pl_hs     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                pkt_ready_o = |is_allocatable_i;
                w_pkt_hs    = pkt_valid_i && (|is_allocatable_i);
                if (w_pkt_hs) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                pl_ready_o = on_off_i[r_vc];
                w_pl_hs    = pl_valid_i && on_off_i[r_vc];
                if (w_pl_hs && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_flit       = '0;
        w_flit.vc_id = r_vc;
        if (r_len == LEN_W'(1)) begin
            w_flit.label = LBL_HEADTAIL;
        end else if (r_cnt == '0) begin
            w_flit.label = LBL_HEAD;
        end else if (w_last) begin
            w_flit.label = LBL_TAIL;
        end else begin
            w_flit.label = LBL_BODY;
        end
        if (w_flit.label == LBL_HEAD || w_flit.label == LBL_HEADTAIL) begin
            w_flit.data = {r_dest_x, r_dest_y, pl_i[HEAD_PL_W-1:0]};
        end else begin
            w_flit.data = pl_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vc       <= '0;
            r_last_vc  <= VC_W'(VC_NUM - 1);
            r_dest_x   <= '0;
            r_dest_y   <= '0;
            r_len      <= LEN_W'(1);
            r_cnt      <= '0;
            r_flit     <= '0;
            r_flit_vld <= 1'b0;
        end else begin
            r_flit_vld <= w_pl_hs;
            if (w_pl_hs) begin
                r_flit <= w_flit;
            end
            if (w_pkt_hs) begin
                r_vc      <= w_sel_vc;
                r_last_vc <= w_sel_vc;
                r_dest_x  <= pkt_dest_x_i;
                r_dest_y  <= pkt_dest_y_i;
                r_len     <= w_len_clamped;
                r_cnt     <= '0;
            end else if (w_pl_hs) begin
                r_cnt <= w_last ? '0 : r_cnt + LEN_W'(1);
            end
        end
    end

    assign data_o       = r_flit;
    assign valid_flit_o = r_flit_vld;
    assign busy_o       = (r_state == ST_SEND);

`ifdef INJ_STATS_EN
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_flits;
    logic [31:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = (r_state == ST_SEND) && pl_valid_i && !on_off_i[r_vc];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_pkts  <= '0;
            r_stat_flits <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pkt_hs && r_stat_pkts != '1) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
            if (w_pl_hs && r_stat_flits != '1) begin
                r_stat_flits <= r_stat_flits + 32'd1;
            end
            if (w_stall && r_stat_stall != '1) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_pkts_o  = r_stat_pkts;
    assign stat_flits_o = r_stat_flits;
    assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_injection_scheduler.sv
// Directed bench for injection_scheduler: segmentation, round-robin VC pick, backpressure, no-VC hold-off,
// asynchronous reset mid-packet and length coercion. Stats checks apply when INJ_STATS_EN is defined.
module tb_injection_scheduler;

    localparam logic [1:0] L_HEAD     = 2'b00;
    localparam logic [1:0] L_BODY     = 2'b01;
    localparam logic [1:0] L_TAIL     = 2'b10;
    localparam logic [1:0] L_HEADTAIL = 2'b11;

    logic        clk;
    logic        rst;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [3:0]  pkt_dest_x_i;
    logic [3:0]  pkt_dest_y_i;
    logic [3:0]  pkt_len_i;
    logic        pl_valid_i;
    logic [15:0] pl_i;
    logic        pl_ready_o;
    logic [18:0] data_o;
    logic        valid_flit_o;
    logic [1:0]  on_off_i;
    logic [1:0]  is_allocatable_i;
    logic        busy_o;
`ifdef INJ_STATS_EN
    logic [31:0] stat_pkts_o;
    logic [31:0] stat_flits_o;
    logic [31:0] stat_stall_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    injection_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid_i),
        .pkt_ready_o      (pkt_ready_o),
        .pkt_dest_x_i     (pkt_dest_x_i),
        .pkt_dest_y_i     (pkt_dest_y_i),
        .pkt_len_i        (pkt_len_i),
        .pl_valid_i       (pl_valid_i),
        .pl_i             (pl_i),
        .pl_ready_o       (pl_ready_o),
        .data_o           (data_o),
        .valid_flit_o     (valid_flit_o),
        .on_off_i         (on_off_i),
        .is_allocatable_i (is_allocatable_i),
        .busy_o           (busy_o)
`ifdef INJ_STATS_EN
        ,
        .stat_pkts_o      (stat_pkts_o),
        .stat_flits_o     (stat_flits_o),
        .stat_stall_o     (stat_stall_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
        pkt_valid_i  = 1'b1;
        pkt_dest_x_i = dx;
        pkt_dest_y_i = dy;
        pkt_len_i    = len;
        #1;
        check("pkt_ready", {31'd0, pkt_ready_o}, 32'd1);
        tick();
        pkt_valid_i = 1'b0;
        check("busy_after_accept", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic send_flit(input string tag, input logic [15:0] pl, input logic [1:0] lbl,
                             input logic vc, input logic [15:0] exp_data);
        pl_valid_i = 1'b1;
        pl_i       = pl;
        #1;
        check({tag, "_pl_ready"}, {31'd0, pl_ready_o}, 32'd1);
        tick();
        pl_valid_i = 1'b0;
        check({tag, "_valid"}, {31'd0, valid_flit_o}, 32'd1);
        check({tag, "_label"}, {30'd0, data_o[18:17]}, {30'd0, lbl});
        check({tag, "_vc"}, {31'd0, data_o[16]}, {31'd0, vc});
        check({tag, "_data"}, {16'd0, data_o[15:0]}, {16'd0, exp_data});
    endtask

    task automatic one_flit_pkt(input string tag, input logic vc, input logic [7:0] pl);
        send_desc(4'd0, 4'd0, 4'd1);
        send_flit(tag, {8'd0, pl}, L_HEADTAIL, vc, {8'd0, pl});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b0;
        pkt_valid_i      = 1'b0;
        pkt_dest_x_i     = '0;
        pkt_dest_y_i     = '0;
        pkt_len_i        = '0;
        pl_valid_i       = 1'b0;
        pl_i             = '0;
        on_off_i         = 2'b11;
        is_allocatable_i = 2'b00;
        tick();
        tick();
        check("rst_valid", {31'd0, valid_flit_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_data", {13'd0, data_o}, 32'd0);
        check("rst_pkt_ready", {31'd0, pkt_ready_o}, 32'd0);
        check("rst_pl_ready", {31'd0, pl_ready_o}, 32'd0);
`ifdef INJ_STATS_EN
        check("rst_stat_pkts", stat_pkts_o, 32'd0);
`endif
        rst = 1'b1;
        is_allocatable_i = 2'b11;
        tick();

        // Single-flit packet
        send_desc(4'd2, 4'd3, 4'd1);
        send_flit("t1", 16'h0055, L_HEADTAIL, 1'b0, 16'h2355);
        check("t1_busy_idle", {31'd0, busy_o}, 32'd0);
        tick();
        check("t1_valid_drop", {31'd0, valid_flit_o}, 32'd0);

        // Four-flit packet; VC1 because VC0 was used last
        send_desc(4'd1, 4'd2, 4'd4);
        send_flit("t2_head", 16'h000A, L_HEAD, 1'b1, 16'h120A);
        send_flit("t2_body0", 16'h000B, L_BODY, 1'b1, 16'h000B);
        send_flit("t2_body1", 16'h000C, L_BODY, 1'b1, 16'h000C);
        send_flit("t2_tail", 16'h000D, L_TAIL, 1'b1, 16'h000D);
        check("t2_busy_idle", {31'd0, busy_o}, 32'd0);

        // Round robin, back-to-back
        one_flit_pkt("t3_rr0", 1'b0, 8'h07);
        one_flit_pkt("t3_rr1", 1'b1, 8'h08);
        one_flit_pkt("t3_rr2", 1'b0, 8'h09);
        is_allocatable_i = 2'b01;
        one_flit_pkt("t3_only0a", 1'b0, 8'h0A);
        one_flit_pkt("t3_only0b", 1'b0, 8'h0B);
        is_allocatable_i = 2'b11;

        // Backpressure on VC1 for five cycles after HEAD
        send_desc(4'd5, 4'd6, 4'd3);
        send_flit("t4_head", 16'h0011, L_HEAD, 1'b1, 16'h5611);
        on_off_i   = 2'b01;
        pl_valid_i = 1'b1;
        pl_i       = 16'h0022;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_stall_pl_ready", {31'd0, pl_ready_o}, 32'd0);
            tick();
            check("t4_stall_valid", {31'd0, valid_flit_o}, 32'd0);
        end
        on_off_i = 2'b11;
        send_flit("t4_body", 16'h0022, L_BODY, 1'b1, 16'h0022);
        send_flit("t4_tail", 16'h0033, L_TAIL, 1'b1, 16'h0033);
        check("t4_busy_idle", {31'd0, busy_o}, 32'd0);
`ifdef INJ_STATS_EN
        check("t4_stat_stall", stat_stall_o, 32'd5);
        check("t4_stat_pkts", stat_pkts_o, 32'd8);
        check("t4_stat_flits", stat_flits_o, 32'd13);
`endif

        // No allocatable VC
        is_allocatable_i = 2'b00;
        pkt_valid_i      = 1'b1;
        pkt_dest_x_i     = 4'd7;
        pkt_dest_y_i     = 4'd1;
        pkt_len_i        = 4'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_pkt_ready", {31'd0, pkt_ready_o}, 32'd0);
            tick();
            check("t5_busy", {31'd0, busy_o}, 32'd0);
            check("t5_valid", {31'd0, valid_flit_o}, 32'd0);
        end
        is_allocatable_i = 2'b10;
        send_desc(4'd7, 4'd1, 4'd1);
        send_flit("t5_flit", 16'h0099, L_HEADTAIL, 1'b1, 16'h7199);
        is_allocatable_i = 2'b11;

        // Asynchronous reset after HEAD of a four-flit packet
        send_desc(4'd3, 4'd3, 4'd4);
        send_flit("t6_head", 16'h00A1, L_HEAD, 1'b0, 16'h33A1);
        pl_valid_i = 1'b1;
        pl_i       = 16'h00B2;
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, valid_flit_o}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_pl_ready", {31'd0, pl_ready_o}, 32'd0);
`ifdef INJ_STATS_EN
        check("t6_rst_stat_pkts", stat_pkts_o, 32'd0);
`endif
        tick();
        rst        = 1'b1;
        pl_valid_i = 1'b0;
        tick();
        check("t6_no_tail", {31'd0, valid_flit_o}, 32'd0);
        send_desc(4'd1, 4'd1, 4'd1);
        send_flit("t6_after", 16'h0042, L_HEADTAIL, 1'b0, 16'h1142);

        // Length 0 coerced to 1, length 9 clamped to 8
        send_desc(4'd4, 4'd4, 4'd0);
        send_flit("t7_len0", 16'h0033, L_HEADTAIL, 1'b1, 16'h4433);
        send_desc(4'd2, 4'd1, 4'd9);
        send_flit("t7_head", 16'h0050, L_HEAD, 1'b0, 16'h2150);
        for (int i = 1; i < 7; i++) begin
            send_flit("t7_body", 16'(16'h0050 + i), L_BODY, 1'b0, 16'(16'h0050 + i));
        end
        send_flit("t7_tail", 16'h0057, L_TAIL, 1'b0, 16'h0057);
        check("t7_busy_idle", {31'd0, busy_o}, 32'd0);
`ifdef INJ_STATS_EN
        check("t7_stat_pkts", stat_pkts_o, 32'd3);
        check("t7_stat_flits", stat_flits_o, 32'd10);
        check("t7_stat_stall", stat_stall_o, 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
